// File: rtl/tick_pkg.sv
// Shared defaults and width helpers for the tick rate generator.
package tick_pkg;

  localparam int BASE_PERIOD_DEF = 100000000;
  localparam int NUM_RATES_DEF   = 4;

  // Speed index width: at least one bit even for a single rate.
  function automatic int spd_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_speed_ctrl.sv
// Speed index register with wrap or saturate stepping.
// speed_changed flags every accepted request, including a saturated no-op,
// so the period counter can restart its phase in the same cycle.
module tick_speed_ctrl
  import tick_pkg::*;
#(
  parameter int NUM_RATES = NUM_RATES_DEF,
  parameter int WRAP      = 1,
  parameter int SPD_W     = spd_w(NUM_RATES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             speed_up,
  input  logic             slow_down,
  output logic [SPD_W-1:0] speed,
  output logic             speed_changed
);

  localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(NUM_RATES - 1);

  logic [SPD_W-1:0] speed_nxt;

  // Next speed: step up/down, wrapping or holding at the ends; both requests cancel.
  always_comb begin
    speed_nxt     = speed;
    speed_changed = speed_up ^ slow_down;
    if (speed_up && !slow_down) begin
      if (speed == SPD_MAX) speed_nxt = (WRAP != 0) ? '0 : SPD_MAX;
      else                  speed_nxt = speed + SPD_W'(1);
    end else if (slow_down && !speed_up) begin
      if (speed == '0) speed_nxt = (WRAP != 0) ? SPD_MAX : '0;
      else             speed_nxt = speed - SPD_W'(1);
    end
  end

  // Speed register.
  always_ff @(posedge clk) begin
    if (rst) speed <= '0;
    else     speed <= speed_nxt;
  end

endmodule

// File: rtl/tick_rate_gen.sv
// Periodic tick generator with selectable rate: period = BASE_PERIOD >> speed.
// pulse is registered and appears the cycle after the counter hits P-1.
module tick_rate_gen
  import tick_pkg::*;
#(
  parameter int BASE_PERIOD = BASE_PERIOD_DEF,
  parameter int NUM_RATES   = NUM_RATES_DEF,
  parameter int WRAP        = 1,
  parameter int CNT_W       = 28
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          speed_up,
  input  logic                          slow_down,
  output logic                          pulse,
  output logic [spd_w(NUM_RATES)-1:0]   speed
);

  localparam int SPD_W = spd_w(NUM_RATES);

  if (((BASE_PERIOD >> (NUM_RATES - 1)) < 2) ||
      (longint'(BASE_PERIOD) >= (longint'(1) << CNT_W))) begin : g_param_check
    $error("tick_rate_gen: fastest period must be >= 2 and BASE_PERIOD must fit in CNT_W bits");
  end

  logic             speed_changed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_last;
  logic [CNT_W-1:0] last_tbl [NUM_RATES];

  tick_speed_ctrl #(
    .NUM_RATES (NUM_RATES),
    .WRAP      (WRAP),
    .SPD_W     (SPD_W)
  ) u_speed_ctrl (
    .clk           (clk),
    .rst           (rst),
    .speed_up      (speed_up),
    .slow_down     (slow_down),
    .speed         (speed),
    .speed_changed (speed_changed)
  );

  // Terminal counts are constants per speed, so the "shift" is just a small mux.
  for (genvar s = 0; s < NUM_RATES; s++) begin : g_last
    assign last_tbl[s] = CNT_W'((BASE_PERIOD >> s) - 1);
  end

  assign cnt_last = last_tbl[speed];

  // Period counter and tick; a speed request restarts the phase and eats the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (speed_changed) begin
        cnt <= '0;
      end else if (enable) begin
        if (cnt == cnt_last) begin
          cnt   <= '0;
          pulse <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_rate_gen.sv
// Directed bench for tick_rate_gen with BASE_PERIOD=16, NUM_RATES=4, CNT_W=5.
// u_wrap has WRAP=1, u_sat has WRAP=0; both share all inputs.
module tb_tick_rate_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       speed_up = 1'b0;
  logic       slow_down = 1'b0;
  logic       pulse_w, pulse_s;
  logic [1:0] speed_w, speed_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_rate_gen #(.BASE_PERIOD(16), .NUM_RATES(4), .WRAP(1), .CNT_W(5)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .speed_up(speed_up),
    .slow_down(slow_down), .pulse(pulse_w), .speed(speed_w));

  tick_rate_gen #(.BASE_PERIOD(16), .NUM_RATES(4), .WRAP(0), .CNT_W(5)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .speed_up(speed_up),
    .slow_down(slow_down), .pulse(pulse_s), .speed(speed_s));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Steps until the selected pulse is seen high; -1 if the budget runs out.
  task automatic wait_pulse(input bit sat, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if ((sat ? pulse_s : pulse_w) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  int n;
  int exp_spd [4] = '{1, 2, 3, 0};
  int p;
  bit seen;

  initial begin
    // Reset state and first pulses at speed 0
    speed_up  = 1'b1;
    steps(2);
    speed_up  = 1'b0;
    check("rst_pulse_w", int'(pulse_w), 0);
    check("rst_speed_w", int'(speed_w), 0);
    check("rst_speed_s", int'(speed_s), 0);
    rst = 1'b0;
    wait_pulse(1'b0, 40, n); check("first_pulse", n, 16);
    step();                  check("pulse_one_cycle", int'(pulse_w), 0);
    wait_pulse(1'b0, 40, n); check("period16_a", n + 1, 16);
    wait_pulse(1'b0, 40, n); check("period16_b", n, 16);
    check("speed0", int'(speed_w), 0);

    // WRAP=1: four speed_up requests 40 cycles apart
    do_reset();
    steps(3);
    for (int k = 0; k < 4; k++) begin
      p = 16 >> exp_spd[k];
      speed_up = 1'b1;
      step();
      speed_up = 1'b0;
      check($sformatf("wrap_speed_%0d", k), int'(speed_w), exp_spd[k]);
      wait_pulse(1'b0, 40, n); check($sformatf("wrap_first_%0d", k), n, p);
      wait_pulse(1'b0, 40, n); check($sformatf("wrap_period_%0d", k), n, p);
      steps(39 - 2 * p);
    end

    // WRAP=0: slow_down at speed 0 holds and restarts the period
    do_reset();
    steps(5);
    slow_down = 1'b1;
    step();
    slow_down = 1'b0;
    check("sat_low_speed", int'(speed_s), 0);
    wait_pulse(1'b1, 40, n); check("sat_low_restart", n, 16);
    for (int k = 0; k < 3; k++) begin
      speed_up = 1'b1;
      step();
    end
    speed_up = 1'b0;
    check("sat_reach3", int'(speed_s), 3);
    step();
    speed_up = 1'b1;           // counter sits at P-1 = 1 here
    step();
    speed_up = 1'b0;
    check("sat_high_speed", int'(speed_s), 3);
    check("sat_high_nopulse", int'(pulse_s), 0);
    wait_pulse(1'b1, 40, n); check("sat_high_restart", n, 2);

    // Both requests together: no change in speed or phase
    do_reset();
    steps(5);
    speed_up  = 1'b1;
    slow_down = 1'b1;
    step();
    speed_up  = 1'b0;
    slow_down = 1'b0;
    check("both_speed", int'(speed_w), 0);
    wait_pulse(1'b0, 40, n); check("both_phase", n, 10);
    wait_pulse(1'b0, 40, n); check("both_period", n, 16);

    // Enable gap of 5 cycles at count 7
    do_reset();
    steps(7);
    enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (pulse_w === 1'b1) seen = 1'b1;
    end
    check("gap_nopulse", int'(seen), 0);
    enable = 1'b1;
    wait_pulse(1'b0, 40, n); check("gap_resume", n, 9);
    wait_pulse(1'b0, 40, n); check("gap_period", n, 16);

    // speed_up on the terminal count, then reset mid-period
    do_reset();
    steps(15);
    speed_up = 1'b1;
    step();
    speed_up = 1'b0;
    check("tc_nopulse", int'(pulse_w), 0);
    check("tc_speed", int'(speed_w), 1);
    wait_pulse(1'b0, 40, n); check("tc_restart", n, 8);
    steps(3);
    rst = 1'b1;
    speed_up = 1'b1;
    step();
    speed_up = 1'b0;
    check("midrst_nopulse", int'(pulse_w), 0);
    check("midrst_speed", int'(speed_w), 0);
    rst = 1'b0;
    wait_pulse(1'b0, 40, n); check("midrst_first", n, 16);
    check("midrst_speed_after", int'(speed_w), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_rate_gen.md
TICK_RATE_GEN -- requirements
Module: tick_rate_gen

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 100000000, meaning cycles between pulses at speed 0 (1 s at 100 MHz).
REQ-002 SHALL have parameter NUM_RATES, default 4, meaning number of selectable speeds; speed s has period BASE_PERIOD >> s.
REQ-003 SHALL have parameter WRAP, default 1, meaning speed stepping wraps when 1 and saturates when 0.
REQ-004 SHALL have parameter CNT_W, default 28, meaning period counter width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1, meaning counting runs when high and freezes when low.
REQ-008 SHALL have port speed_up, input, 1, meaning a single-cycle request for the next faster speed (pre-debounced).
REQ-009 SHALL have port slow_down, input, 1, meaning a single-cycle request for the next slower speed.
REQ-010 SHALL have port pulse, output, 1, meaning a one-cycle tick.
REQ-011 SHALL have port speed, output, SPD_W = max(1, clog2(NUM_RATES)), meaning the current speed index.

Function
REQ-012 SHALL keep a period counter that counts 0..P-1 with P = BASE_PERIOD >> speed, then returns to 0.
REQ-013 SHALL register pulse: pulse = 1 in the cycle after the counter equals P-1 while enable = 1, so steady-state pulses are exactly P cycles apart.
REQ-014 SHALL hold the counter and force pulse to 0 in the following cycle while enable = 0; counting resumes from the held value.
REQ-015 SHALL, on speed_up = 1 and slow_down = 0, raise speed by 1; at NUM_RATES-1 it goes to 0 if WRAP = 1 and holds if WRAP = 0.
REQ-016 SHALL, on slow_down = 1 and speed_up = 0, lower speed by 1; at 0 it goes to NUM_RATES-1 if WRAP = 1 and holds if WRAP = 0.
REQ-017 SHALL make no speed change and no counter clear when speed_up and slow_down are both 1.
REQ-018 SHALL clear the counter to 0 in the same cycle as any accepted speed change, including a saturated no-op, regardless of enable, and SHALL issue no pulse for that terminal count.
REQ-019 SHALL let a speed request on the cycle where the counter equals P-1 win: the counter clears and the pulse is suppressed.
REQ-020 SHALL apply a new speed value to the period compare from the cycle after the change.
REQ-021 SHALL compute the period by a constant right shift of BASE_PERIOD, with no divider.
REQ-022 SHALL compare the counter against P-1 at CNT_W bits.

Reset
REQ-023 SHALL, on rst = 1 at a clock edge, set counter = 0, speed = 0 and pulse = 0, overriding all other inputs that cycle.
REQ-024 SHALL produce the first pulse after reset release BASE_PERIOD cycles after the first non-reset edge, provided enable is held high.
REQ-025 SHALL, on reset mid-period, discard the partial count; no pulse may appear in the cycle after reset.

Structure
REQ-026 SHALL place BASE_PERIOD default, NUM_RATES default and the SPD_W derivation in shared package tick_pkg.
REQ-027 SHALL implement the speed register and its wrap/saturate logic in one sub-module, tick_speed_ctrl, which outputs speed and a speed_changed strobe.
REQ-028 SHALL fail elaboration unless (BASE_PERIOD >> (NUM_RATES-1)) >= 2 and BASE_PERIOD < 2**CNT_W.
REQ-029 SHALL have RTL size of about 120-250 lines.

Verification
Benches use BASE_PERIOD = 16, NUM_RATES = 4, CNT_W = 5, so periods are 16/8/4/2.
REQ-030 SHALL check reset release with enable = 1: the first pulse arrives 16 cycles later, then pulses repeat every 16 cycles, and speed = 0.
REQ-031 SHALL check WRAP = 1 with speed_up pulsed 4 times, 40 cycles apart: speed goes 1, 2, 3, 0, with pulse spacing 8, 4, 2, 16 after each change.
REQ-032 SHALL check WRAP = 0 with slow_down at speed 0 and speed_up at speed 3: speed holds, the counter clears and the next pulse comes a full period later.
REQ-033 SHALL check speed_up and slow_down high together: speed, counter phase and pulse spacing are unchanged.
REQ-034 SHALL check enable dropped for 5 cycles mid-period at count 7 (speed 0): no pulse during the gap, and the next pulse comes 9 enabled cycles after resumption.
REQ-035 SHALL check speed_up on the terminal-count cycle, then rst asserted mid-period: the pulse is suppressed; after reset, speed = 0 and the first pulse comes 16 cycles later.
